// File: rtl/muntjac_fpu_mul_arbiter.sv
// Round-robin arbiter sharing one combinational FP multiplier core between two requesters,
// with a Latency-deep result pipeline that routes each product back to its requester.
module muntjac_fpu_mul_arbiter #(
    parameter int unsigned InExpWidth = 9,
    parameter int unsigned InSigWidth = 23,
    parameter int unsigned Latency    = 2,
    localparam int unsigned OpWidth   = 2 * (InExpWidth + InSigWidth + 4),
    localparam int unsigned ResWidth  = 2 * InSigWidth + InExpWidth + 7
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                req0_valid_i,
    output logic                req0_ready_o,
    input  logic [OpWidth-1:0]  req0_op_i,
    output logic                resp0_valid_o,
    input  logic                resp0_ready_i,
    output logic [ResWidth-1:0] resp0_data_o,

    input  logic                req1_valid_i,
    output logic                req1_ready_o,
    input  logic [OpWidth-1:0]  req1_op_i,
    output logic                resp1_valid_o,
    input  logic                resp1_ready_i,
    output logic [ResWidth-1:0] resp1_data_o,

    output logic [OpWidth-1:0]  mul_op_o,
    input  logic [ResWidth-1:0] mul_res_i
);

    logic [Latency-1:0]  stageValid_q;
    logic [Latency-1:0]  stageId_q;
    logic [ResWidth-1:0] stageData_q [Latency];
    logic                ptr_q;
    logic                ptr_d;

    logic headId;
    logic outFire;
    logic adv;
    logic grantValid;
    logic winner;

    // Grants are suppressed while reset is asserted so no requester sees a spurious accept.
    always_comb begin
        headId     = stageId_q[Latency-1];
        outFire    = stageValid_q[Latency-1] && (headId ? resp1_ready_i : resp0_ready_i);
        adv        = !stageValid_q[Latency-1] || outFire;
        grantValid = 1'b0;
        winner     = 1'b0;
        ptr_d      = ptr_q;
        if (adv && rst_ni) begin
            if (req0_valid_i && req1_valid_i) begin
                grantValid = 1'b1;
                winner     = ptr_q;
                ptr_d      = ~ptr_q;
            end else if (req0_valid_i) begin
                grantValid = 1'b1;
                winner     = 1'b0;
            end else if (req1_valid_i) begin
                grantValid = 1'b1;
                winner     = 1'b1;
            end
        end
    end

    assign req0_ready_o  = grantValid && !winner;
    assign req1_ready_o  = grantValid && winner;
    assign mul_op_o      = grantValid ? (winner ? req1_op_i : req0_op_i) : '0;

    assign resp0_valid_o = stageValid_q[Latency-1] && !headId;
    assign resp1_valid_o = stageValid_q[Latency-1] && headId;
    assign resp0_data_o  = stageData_q[Latency-1];
    assign resp1_data_o  = stageData_q[Latency-1];

    // The whole pipeline moves together or holds together; bubbles are never collapsed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stageValid_q <= '0;
            stageId_q    <= '0;
            ptr_q        <= 1'b0;
            for (int k = 0; k < Latency; k++) begin
                stageData_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = Latency - 1; k > 0; k--) begin
                stageValid_q[k] <= stageValid_q[k-1];
                stageId_q[k]    <= stageId_q[k-1];
                stageData_q[k]  <= stageData_q[k-1];
            end
            stageValid_q[0] <= grantValid;
            if (grantValid) begin
                stageId_q[0]   <= winner;
                stageData_q[0] <= mul_res_i;
            end
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: tb/tb_muntjac_fpu_mul_arbiter.sv
// Directed and random checks of the multiplier arbiter; the bench itself plays the multiplier core.
module tb_muntjac_fpu_mul_arbiter;

    localparam int E  = 9;
    localparam int S  = 23;
    localparam int L  = 2;
    localparam int FW = E + S + 4;
    localparam int OW = 2 * FW;
    localparam int RW = 2 * S + E + 7;

    logic clk = 1'b0;
    logic rstN;
    logic req0Valid, req0Ready, resp0Valid, resp0ReadyIn;
    logic req1Valid, req1Ready, resp1Valid, resp1ReadyIn;
    logic [OW-1:0] req0Op, req1Op, mulOp;
    logic [RW-1:0] resp0Data, resp1Data, mulRes;

    int totalChecks = 0;
    int badChecks   = 0;
    logic [RW-1:0] exp0Q[$];
    logic [RW-1:0] exp1Q[$];

    typedef struct packed {
        logic          id;
        logic [OW-1:0] op;
        logic          expInvalid;
        logic          expNan;
    } vec_t;

    always #5 clk = ~clk;

    muntjac_fpu_mul_arbiter #(.InExpWidth(E), .InSigWidth(S), .Latency(L)) dut (
        .clk_i(clk), .rst_ni(rstN),
        .req0_valid_i(req0Valid), .req0_ready_o(req0Ready), .req0_op_i(req0Op),
        .resp0_valid_o(resp0Valid), .resp0_ready_i(resp0ReadyIn), .resp0_data_o(resp0Data),
        .req1_valid_i(req1Valid), .req1_ready_o(req1Ready), .req1_op_i(req1Op),
        .resp1_valid_o(resp1Valid), .resp1_ready_i(resp1ReadyIn), .resp1_data_o(resp1Data),
        .mul_op_o(mulOp), .mul_res_i(mulRes)
    );

    function automatic logic [FW-1:0] mkOp(input logic sgn, input logic [E-1:0] ex,
                                            input logic [S-1:0] sig, input logic zero,
                                            input logic inf, input logic nan);
        return {sgn, ex, sig, zero, inf, nan};
    endfunction

    // Behavioural stand-in for the multiplier core: flags, signed exponent sum, normalised fraction.
    function automatic logic [RW-1:0] coreModel(input logic [OW-1:0] op);
        logic [FW-1:0] a, b;
        logic [2*S+1:0] prod;
        logic signed [E:0] ex;
        logic [2*S:0] sig;
        logic snanA, snanB, inv, nan, inf, zero;
        a     = op[OW-1:FW];
        b     = op[FW-1:0];
        prod  = {{(S+1){1'b0}}, 1'b1, a[S+2:3]} * {{(S+1){1'b0}}, 1'b1, b[S+2:3]};
        ex    = $signed({a[FW-2], a[FW-2 -: E]}) + $signed({b[FW-2], b[FW-2 -: E]});
        if (prod[2*S+1]) begin
            sig = prod[2*S:0];
            ex  = ex + 1;
        end else begin
            sig = {prod[2*S-1:0], 1'b0};
        end
        snanA = a[0] && !a[S+2];
        snanB = b[0] && !b[S+2];
        inv   = (a[1] && b[2]) || (a[2] && b[1]) || snanA || snanB;
        nan   = a[0] || b[0] || inv;
        inf   = !nan && (a[1] || b[1]);
        zero  = !nan && !inf && (a[2] || b[2]);
        return {inv, a[FW-1] ^ b[FW-1], ex, sig, zero, inf, nan};
    endfunction

    function automatic logic [OW-1:0] genOp(input int r, input int k);
        return {mkOp(r[0], E'(k), S'(k * 977 + r * 13 + 1), 1'b0, 1'b0, 1'b0),
                mkOp(1'b0, E'(r + 1), S'(k * 31 + 5), 1'b0, 1'b0, 1'b0)};
    endfunction

    assign mulRes = coreModel(mulOp);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        totalChecks++;
        if (act !== expv) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v0, input logic [OW-1:0] o0, input logic v1,
                                 input logic [OW-1:0] o1, input logic rr0, input logic rr1);
        req0Valid    = v0;
        req0Op       = o0;
        req1Valid    = v1;
        req1Op       = o1;
        resp0ReadyIn = rr0;
        resp1ReadyIn = rr1;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic r0, input logic r1,
                               input logic v0, input logic v1, input logic [RW-1:0] d);
        check({name, " req0Ready"}, req0Ready, r0);
        check({name, " req1Ready"}, req1Ready, r1);
        check({name, " resp0Valid"}, resp0Valid, v0);
        check({name, " resp1Valid"}, resp1Valid, v1);
        if (v0 || v1) begin
            check({name, " resp0Data"}, resp0Data, d);
            check({name, " resp1Data"}, resp1Data, d);
        end
    endtask

    task automatic scoreCycle(input logic v0, input logic [OW-1:0] o0, input logic v1,
                              input logic [OW-1:0] o1, input logic rr0, input logic rr1);
        check("rnd readyOneHot", req0Ready && req1Ready, 1'b0);
        check("rnd respOneHot", resp0Valid && resp1Valid, 1'b0);
        if (req0Ready) begin
            check("rnd ready0 without valid", v0, 1'b1);
            exp0Q.push_back(coreModel(o0));
        end
        if (req1Ready) begin
            check("rnd ready1 without valid", v1, 1'b1);
            exp1Q.push_back(coreModel(o1));
        end
        if (resp0Valid && rr0) begin
            if (exp0Q.size() == 0) begin
                totalChecks++;
                badChecks++;
                $display("[TB] FAIL rnd resp0 unexpected: got data %0h want no response", resp0Data);
            end else begin
                check("rnd resp0 data", resp0Data, exp0Q.pop_front());
            end
        end
        if (resp1Valid && rr1) begin
            if (exp1Q.size() == 0) begin
                totalChecks++;
                badChecks++;
                $display("[TB] FAIL rnd resp1 unexpected: got data %0h want no response", resp1Data);
            end else begin
                check("rnd resp1 data", resp1Data, exp1Q.pop_front());
            end
        end
    endtask

    initial begin
        vec_t vecs[6];
        logic [FW-1:0] one, two, oneHalf, negTwo, infOp, zeroOp, snanOp, qnanOp, three;
        logic [OW-1:0] opA, opB, opC, opD;
        logic [RW-1:0] expD;
        logic v0, v1, rr0, rr1, acc0, acc1;
        logic [OW-1:0] o0, o1;

        one     = mkOp(1'b0, 9'd0, 23'h0,      1'b0, 1'b0, 1'b0);
        two     = mkOp(1'b0, 9'd1, 23'h0,      1'b0, 1'b0, 1'b0);
        oneHalf = mkOp(1'b0, 9'd0, 23'h400000, 1'b0, 1'b0, 1'b0);
        negTwo  = mkOp(1'b1, 9'd1, 23'h0,      1'b0, 1'b0, 1'b0);
        infOp   = mkOp(1'b0, 9'd0, 23'h0,      1'b0, 1'b1, 1'b0);
        zeroOp  = mkOp(1'b0, 9'd0, 23'h0,      1'b1, 1'b0, 1'b0);
        snanOp  = mkOp(1'b0, 9'd0, 23'h200000, 1'b0, 1'b0, 1'b1);
        qnanOp  = mkOp(1'b0, 9'd0, 23'h400000, 1'b0, 1'b0, 1'b1);
        three   = mkOp(1'b0, 9'd1, 23'h400000, 1'b0, 1'b0, 1'b0);
        vecs[0] = '{1'b0, {oneHalf, two},  1'b0, 1'b0};
        vecs[1] = '{1'b1, {one, negTwo},   1'b0, 1'b0};
        vecs[2] = '{1'b1, {infOp, zeroOp}, 1'b1, 1'b1};
        vecs[3] = '{1'b0, {snanOp, one},   1'b1, 1'b1};
        vecs[4] = '{1'b0, {qnanOp, one},   1'b0, 1'b1};
        vecs[5] = '{1'b1, {zeroOp, three}, 1'b0, 1'b0};

        rstN = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("reset resp0Data", resp0Data, '0);
        check("reset mulOp", mulOp, '0);
        rstN = 1'b1;
        tick();

        // Single operations, one requester at a time, exact two-cycle latency.
        for (int i = 0; i < 6; i++) begin
            expD = coreModel(vecs[i].op);
            applyStimulus(!vecs[i].id, vecs[i].op, vecs[i].id, vecs[i].op, 1'b1, 1'b1);
            checkOutput($sformatf("vec%0d issue", i), !vecs[i].id, vecs[i].id, 1'b0, 1'b0, '0);
            check($sformatf("vec%0d mulOp", i), mulOp, vecs[i].op);
            tick();
            applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
            checkOutput($sformatf("vec%0d wait", i), 1'b0, 1'b0, 1'b0, 1'b0, '0);
            tick();
            checkOutput($sformatf("vec%0d resp", i), 1'b0, 1'b0, !vecs[i].id, vecs[i].id, expD);
            check($sformatf("vec%0d invalid", i), resp0Data[RW-1], vecs[i].expInvalid);
            check($sformatf("vec%0d nan", i), resp0Data[0], vecs[i].expNan);
            if (i == 0) begin
                check("vec0 exp", resp0Data[RW-3 -: E+1], 10'd1);
                check("vec0 sig", resp0Data[2*S+3:3], 47'h400000000000);
            end
            tick();
        end

        // Contention: both requesters valid for six cycles, grants alternate starting at 0.
        for (int c = 0; c < 8; c++) begin
            expD = coreModel(genOp((c - 2) % 2, (c - 2) / 2));
            applyStimulus(c < 6, genOp(0, (c + 1) / 2), c < 6, genOp(1, c / 2), 1'b1, 1'b1);
            checkOutput($sformatf("contend c%0d", c), c < 6 && c % 2 == 0, c < 6 && c % 2 == 1,
                        c >= 2 && c % 2 == 0, c >= 2 && c % 2 == 1, expD);
            tick();
        end

        // Backpressure: head stalls on resp0, nothing is accepted, then drain in order.
        opA = genOp(0, 10);
        opB = genOp(0, 11);
        opC = genOp(0, 12);
        opD = genOp(1, 13);
        applyStimulus(1'b1, opA, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("bp fillA", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        tick();
        applyStimulus(1'b1, opB, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("bp fillB", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        tick();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, opC, 1'b1, opD, 1'b0, 1'b1);
            checkOutput($sformatf("bp stall%0d", c), 1'b0, 1'b0, 1'b1, 1'b0, coreModel(opA));
            tick();
        end
        applyStimulus(1'b1, opC, 1'b1, opD, 1'b1, 1'b1);
        checkOutput("bp releaseA", 1'b1, 1'b0, 1'b1, 1'b0, coreModel(opA));
        tick();
        applyStimulus(1'b0, '0, 1'b1, opD, 1'b1, 1'b1);
        checkOutput("bp drainB", 1'b0, 1'b1, 1'b1, 1'b0, coreModel(opB));
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("bp drainC", 1'b0, 1'b0, 1'b1, 1'b0, coreModel(opC));
        tick();
        checkOutput("bp drainD", 1'b0, 1'b0, 1'b0, 1'b1, coreModel(opD));
        tick();
        checkOutput("bp empty", 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Reset with two ops in flight and the pointer at requester 1.
        applyStimulus(1'b1, genOp(0, 20), 1'b0, '0, 1'b1, 1'b1);
        checkOutput("rst issue0", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, genOp(1, 21), 1'b1, 1'b1);
        checkOutput("rst issue1", 1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick();
        rstN = 1'b0;
        applyStimulus(1'b1, genOp(0, 22), 1'b1, genOp(1, 22), 1'b1, 1'b1);
        checkOutput("rst asserted", 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("rst mulOp", mulOp, '0);
        check("rst data", resp0Data, '0);
        tick();
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        rstN = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("rst idle%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, '0);
        end
        applyStimulus(1'b1, genOp(0, 23), 1'b1, genOp(1, 23), 1'b1, 1'b1);
        checkOutput("rst ptr0", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, genOp(1, 23), 1'b1, 1'b1);
        checkOutput("rst next1", 1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("rst resp0", 1'b0, 1'b0, 1'b1, 1'b0, coreModel(genOp(0, 23)));
        tick();
        checkOutput("rst resp1", 1'b0, 1'b0, 1'b0, 1'b1, coreModel(genOp(1, 23)));
        tick();

        // Random sweep: requesters hold ops until accepted, random response backpressure.
        v0 = 1'b0;
        v1 = 1'b0;
        o0 = '0;
        o1 = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!v0 && $urandom_range(0, 99) < 60) begin
                v0 = 1'b1;
                o0 = OW'({$urandom, $urandom, $urandom});
            end
            if (!v1 && $urandom_range(0, 99) < 60) begin
                v1 = 1'b1;
                o1 = OW'({$urandom, $urandom, $urandom});
            end
            rr0 = $urandom_range(0, 99) < 75;
            rr1 = $urandom_range(0, 99) < 75;
            applyStimulus(v0, o0, v1, o1, rr0, rr1);
            scoreCycle(v0, o0, v1, o1, rr0, rr1);
            acc0 = req0Ready;
            acc1 = req1Ready;
            tick();
            if (acc0) v0 = 1'b0;
            if (acc1) v1 = 1'b0;
        end
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
            scoreCycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
            tick();
        end
        check("rnd drained0", exp0Q.size(), 0);
        check("rnd drained1", exp1Q.size(), 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
